// File: rtl/hbm_pkg.sv
// Shared constants for the HBM frame store: AXI encodings, frame geometry and
// the read-side state encoding.
package hbm_pkg;

    localparam int HBM_DATA_W      = 128;
    localparam int HBM_ADDR_W      = 29;
    localparam int HBM_BURST_LEN   = 100;
    localparam int HBM_BURST_BYTES = 32'h0000_0640;
    localparam int HBM_NUM_BURSTS  = 5;
    localparam int HBM_FIFO_DEPTH  = 256;

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_ID_ZERO    = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_e;

    // A partially returned burst is counted both in the FIFO and as outstanding,
    // so the check is conservative and can never admit an overflowing burst.
    function automatic logic credit_ok(input int fifo_cnt, input int outstanding,
                                       input int burst_len, input int depth);
        return (fifo_cnt + outstanding * burst_len + burst_len) <= depth;
    endfunction

endpackage

// File: rtl/hbm_frame_reader_if.sv
// AXI read-address / read-data channel bundle between the frame reader and HBM.
interface hbm_frame_reader_if
    import hbm_pkg::*;
#(
    parameter int DATA_W = HBM_DATA_W,
    parameter int ADDR_W = HBM_ADDR_W
);
    logic [ADDR_W-1:0] AXI_ARADDR;
    logic [7:0]        AXI_ARLEN;
    logic [2:0]        AXI_ARSIZE;
    logic [1:0]        AXI_ARBURST;
    logic [3:0]        AXI_ARID;
    logic              AXI_ARVALID;
    logic              AXI_ARREADY;
    logic [DATA_W-1:0] AXI_RDATA;
    logic [3:0]        AXI_RID;
    logic [1:0]        AXI_RRESP;
    logic              AXI_RLAST;
    logic              AXI_RVALID;
    logic              AXI_RREADY;

    modport master (
        output AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARID, AXI_ARVALID, AXI_RREADY,
        input  AXI_ARREADY, AXI_RDATA, AXI_RID, AXI_RRESP, AXI_RLAST, AXI_RVALID
    );

    modport slave (
        input  AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARID, AXI_ARVALID, AXI_RREADY,
        output AXI_ARREADY, AXI_RDATA, AXI_RID, AXI_RRESP, AXI_RLAST, AXI_RVALID
    );
endinterface

// File: rtl/hbm_rd_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, data} beats for the reader.
module hbm_rd_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign push_s  = wr_en && (!full_s || rd_en);
    assign pop_s   = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    hbm_rd_fifo_chk u_chk (.clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .full(full_s));
endmodule

// File: rtl/hbm_rd_fifo_chk.sv
// Simulation-only guard for the read buffer: a write must never land on a full FIFO.
module hbm_rd_fifo_chk (
    input logic clk,
    input logic rst,
    input logic wr_en,
    input logic rd_en,
    input logic full
);
    overflow_a: assert property (@(posedge clk) disable iff (!rst) !(wr_en && full && !rd_en))
        else $error("hbm_rd_fifo: write while full");
endmodule

// File: rtl/hbm_frame_reader.sv
// HBM frame read-back: issues NUM_BURSTS credit-gated AXI INCR bursts and streams
// the returned beats out of a FWFT buffer with per-frame last marking.
module hbm_frame_reader
    import hbm_pkg::*;
#(
    parameter int                DATA_W      = HBM_DATA_W,
    parameter int                ADDR_W      = HBM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
    parameter int                BURST_LEN   = HBM_BURST_LEN,
    parameter int                BURST_BYTES = HBM_BURST_BYTES,
    parameter int                NUM_BURSTS  = HBM_NUM_BURSTS,
    parameter int                FIFO_DEPTH  = HBM_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    hbm_frame_reader_if.master   axi,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    output logic                 dout_last,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BC_W  = $clog2(BURST_LEN);
    localparam int NB_W  = $clog2(NUM_BURSTS + 1);

    rd_state_e         state_r;
    logic [ADDR_W-1:0] araddr_r;
    logic [7:0]        arlen_r;
    logic [2:0]        arsize_r;
    logic [1:0]        arburst_r;
    logic              arvalid_r;
    logic              rready_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_err_r;
    logic [NB_W-1:0]   ar_cnt_r;
    logic [NB_W-1:0]   r_cnt_r;
    logic [BC_W-1:0]   beat_cnt_r;

    logic              r_hs_s;
    logic              beat_last_s;
    logic              r_bad_s;
    logic              credit_s;
    logic [NB_W-1:0]   outst_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic [DATA_W:0]   fifo_rd_s;

    assign r_hs_s      = axi.AXI_RVALID && rready_r;
    assign beat_last_s = (beat_cnt_r == BC_W'(BURST_LEN - 1));
    assign outst_s     = ar_cnt_r - r_cnt_r;
    assign credit_s    = credit_ok(32'(fifo_count_s), 32'(outst_s), BURST_LEN, FIFO_DEPTH);
    assign r_bad_s     = (axi.AXI_RRESP != AXI_RESP_OKAY) || (axi.AXI_RID != AXI_ID_ZERO) ||
                         (axi.AXI_RLAST != beat_last_s);

    assign axi.AXI_ARADDR  = araddr_r;
    assign axi.AXI_ARLEN   = arlen_r;
    assign axi.AXI_ARSIZE  = arsize_r;
    assign axi.AXI_ARBURST = arburst_r;
    assign axi.AXI_ARID    = AXI_ID_ZERO;
    assign axi.AXI_ARVALID = arvalid_r;
    assign axi.AXI_RREADY  = rready_r;

    assign dout       = fifo_rd_s[DATA_W-1:0];
    assign dout_last  = fifo_rd_s[DATA_W];
    assign dout_valid = !fifo_empty_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign rd_err     = rd_err_r;

    hbm_rd_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_hs_s),
        .wr_data ({beat_last_s, axi.AXI_RDATA}),
        .rd_en   (dout_ready),
        .rd_data (fifo_rd_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s)
    );

    // Pass sequencer: AR issue, R beat accounting and error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            araddr_r   <= BASE_ADDR;
            arlen_r    <= 8'h00;
            arsize_r   <= 3'b000;
            arburst_r  <= 2'b00;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_err_r   <= 1'b0;
            ar_cnt_r   <= {NB_W{1'b0}};
            r_cnt_r    <= {NB_W{1'b0}};
            beat_cnt_r <= {BC_W{1'b0}};
        end else begin
            if (r_hs_s) begin
                beat_cnt_r <= beat_last_s ? {BC_W{1'b0}} : beat_cnt_r + BC_W'(1);
                if (beat_last_s) r_cnt_r <= r_cnt_r + NB_W'(1);
                if (r_bad_s)     rd_err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start && credit_s) begin
                        state_r    <= ST_REQ;
                        araddr_r   <= BASE_ADDR;
                        arlen_r    <= 8'(BURST_LEN - 1);
                        arsize_r   <= AXI_SIZE_16B;
                        arburst_r  <= AXI_BURST_INCR;
                        arvalid_r  <= 1'b1;
                        rready_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        ar_cnt_r   <= {NB_W{1'b0}};
                        r_cnt_r    <= {NB_W{1'b0}};
                        beat_cnt_r <= {BC_W{1'b0}};
                    end
                end
                ST_REQ: begin
                    if (axi.AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        ar_cnt_r  <= ar_cnt_r + NB_W'(1);
                        araddr_r  <= araddr_r + ADDR_W'(BURST_BYTES);
                        state_r   <= ((ar_cnt_r + NB_W'(1)) == NB_W'(NUM_BURSTS)) ? ST_DRAIN : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (credit_s) begin
                        arvalid_r <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if ((r_cnt_r == NB_W'(NUM_BURSTS)) && fifo_empty_s) begin
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        rready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hbm_frame_reader.sv
// Directed bench for hbm_frame_reader with a responsive AXI read slave model.
module tb_hbm_frame_reader;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         dout_ready = 1'b0;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_last;
    logic         busy;
    logic         done;
    logic         rd_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    hbm_frame_reader_if #(.DATA_W(128), .ADDR_W(29)) bus ();

    hbm_frame_reader dut (
        .clk(clk), .rst(rst), .start(start), .axi(bus),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy), .done(done), .rd_err(rd_err)
    );

    // Slave model state; data of each beat is its byte address replicated.
    logic         ar_ready_en = 1'b1;
    logic [31:0]  aq [8];
    logic [2:0]   aw = 3'd0;
    logic [2:0]   ax = 3'd0;
    int           rb = 0;
    int           s_rburst = 0;
    int           ar_total = 0;
    logic [31:0]  ar_log [64];
    logic [7:0]   alen_log [64];
    logic         s_rvalid = 1'b0;
    logic         s_rlast = 1'b0;
    logic [127:0] s_rdata = 128'h0;
    logic [1:0]   s_rresp = 2'b00;
    int           err_burst = -1;
    int           lst_burst = -1;
    int           lst_mode = 0;

    assign bus.AXI_ARREADY = ar_ready_en;
    assign bus.AXI_RVALID  = s_rvalid;
    assign bus.AXI_RDATA   = s_rdata;
    assign bus.AXI_RLAST   = s_rlast;
    assign bus.AXI_RRESP   = s_rresp;
    assign bus.AXI_RID     = 4'h0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave: logs AR handshakes and returns 100-beat bursts back to back.
    always @(posedge clk) begin
        if (!rst) begin
            aw <= 3'd0; ax <= 3'd0; rb <= 0; s_rburst <= 0; s_rvalid <= 1'b0;
        end else begin
            if (bus.AXI_ARVALID && bus.AXI_ARREADY) begin
                aq[aw] <= 32'(bus.AXI_ARADDR);
                ar_log[ar_total] <= 32'(bus.AXI_ARADDR);
                alen_log[ar_total] <= bus.AXI_ARLEN;
                aw <= aw + 3'd1;
                ar_total <= ar_total + 1;
            end
            if (!s_rvalid || bus.AXI_RREADY) begin
                if (ax != aw) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= {4{aq[ax] + 32'(rb) * 32'd16}};
                    s_rresp  <= (s_rburst == err_burst && rb == 37) ? 2'b10 : 2'b00;
                    s_rlast  <= (s_rburst == lst_burst && lst_mode == 1) ? (rb == 98) :
                                (s_rburst == lst_burst && lst_mode == 2) ? 1'b0 : (rb == 99);
                    if (rb == 99) begin
                        rb <= 0; ax <= ax + 3'd1; s_rburst <= s_rburst + 1;
                    end else begin
                        rb <= rb + 1;
                    end
                end else begin
                    s_rvalid <= 1'b0;
                end
            end
        end
    end

    // Stream consumer: every beat of a pass must carry address 16*n and last on frame ends.
    int idx = 0;
    int rx_total = 0;
    always @(negedge clk) begin
        if (!rst) begin
            idx <= 0;
        end else if (dout_valid && dout_ready) begin
            check("data", dout, {4{32'(idx * 16)}});
            check("last", 128'(dout_last), 128'((idx % 100) == 99));
            idx <= (idx == 499) ? 0 : idx + 1;
            rx_total <= rx_total + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 5000) begin
            step(1);
            k++;
        end
        check(tag, 128'(done), 128'(1));
    endtask

    int a0;
    int t0;
    int t1;

    initial begin
        step(3);
        check("rst_arvalid", 128'(bus.AXI_ARVALID), 128'(0));
        check("rst_araddr", 128'(bus.AXI_ARADDR), 128'(0));
        check("rst_arlen", 128'(bus.AXI_ARLEN), 128'(0));
        check("rst_rready", 128'(bus.AXI_RREADY), 128'(0));
        check("rst_flags", 128'({dout_valid, dout_last, busy, done, rd_err}), 128'(0));
        rst = 1'b1;
        step(2);

        // Nominal pass
        dout_ready = 1'b1;
        a0 = ar_total; t0 = rx_total;
        pulse_start();
        check("busy_t1", 128'(busy), 128'(1));
        wait_done("done_t1");
        check("beats_t1", 128'(rx_total - t0), 128'(500));
        check("ars_t1", 128'(ar_total - a0), 128'(5));
        for (int k = 0; k < 5; k++) begin
            check("araddr_t1", 128'(ar_log[a0 + k]), 128'(k * 32'h640));
            check("arlen_t1", 128'(alen_log[a0 + k]), 128'(8'h63));
        end
        check("err_t1", 128'(rd_err), 128'(0));
        check("idle_t1", 128'({busy, dout_valid}), 128'(0));

        // ARREADY held low for 20 cycles
        ar_ready_en = 1'b0;
        a0 = ar_total;
        pulse_start();
        check("done_clr", 128'(done), 128'(0));
        check("arsize", 128'(bus.AXI_ARSIZE), 128'(3'b100));
        check("arburst", 128'(bus.AXI_ARBURST), 128'(2'b01));
        check("arid", 128'(bus.AXI_ARID), 128'(0));
        for (int k = 0; k < 20; k++) begin
            check("stall_arvalid", 128'(bus.AXI_ARVALID), 128'(1));
            check("stall_araddr", 128'(bus.AXI_ARADDR), 128'(0));
            check("stall_arlen", 128'(bus.AXI_ARLEN), 128'(8'h63));
            step(1);
        end
        check("stall_no_hs", 128'(ar_total - a0), 128'(0));
        ar_ready_en = 1'b1;
        step(1);
        check("stall_one_hs", 128'(ar_total - a0), 128'(1));
        check("stall_arvalid_lo", 128'(bus.AXI_ARVALID), 128'(0));
        wait_done("done_t3");
        check("ars_t3", 128'(ar_total - a0), 128'(5));

        // Consumer stalled: credit caps the pass at two frames in the buffer
        dout_ready = 1'b0;
        a0 = ar_total; t0 = rx_total;
        pulse_start();
        step(400);
        check("ars_bp", 128'(ar_total - a0), 128'(2));
        check("valid_bp", 128'(dout_valid), 128'(1));
        t1 = rx_total;
        dout_ready = 1'b1;
        for (int k = 0; k < 500 && (rx_total - t1) < 40; k++) step(1);
        dout_ready = 1'b0;
        check("drain40", 128'(rx_total - t1), 128'(40));
        step(40);
        check("ars_bp40", 128'(ar_total - a0), 128'(2));
        dout_ready = 1'b1;
        wait_done("done_t2");
        check("beats_t2", 128'(rx_total - t0), 128'(500));
        check("ars_t2", 128'(ar_total - a0), 128'(5));

        // SLVERR on beat 37 of burst index 2
        err_burst = s_rburst + 2;
        t0 = rx_total;
        pulse_start();
        wait_done("done_t4");
        err_burst = -1;
        check("err_t4", 128'(rd_err), 128'(1));
        check("beats_t4", 128'(rx_total - t0), 128'(500));

        // Reset in the middle of the third burst
        a0 = ar_total;
        pulse_start();
        for (int k = 0; k < 2000 && (ar_total - a0) < 3; k++) step(1);
        step(20);
        rst = 1'b0;
        #1;
        check("mid_arvalid", 128'(bus.AXI_ARVALID), 128'(0));
        check("mid_araddr", 128'(bus.AXI_ARADDR), 128'(0));
        check("mid_rready", 128'(bus.AXI_RREADY), 128'(0));
        check("mid_flags", 128'({dout_valid, dout_last, busy, done, rd_err}), 128'(0));
        step(3);
        rst = 1'b1;
        step(2);
        a0 = ar_total; t0 = rx_total;
        pulse_start();
        wait_done("done_t6");
        check("beats_t6", 128'(rx_total - t0), 128'(500));
        check("ars_t6", 128'(ar_total - a0), 128'(5));
        check("err_t6", 128'(rd_err), 128'(0));

        // RLAST early on beat 98
        lst_burst = s_rburst; lst_mode = 1;
        pulse_start();
        wait_done("done_t5a");
        check("err_t5a", 128'(rd_err), 128'(1));
        rst = 1'b0;
        step(2);
        check("err_cleared", 128'(rd_err), 128'(0));
        rst = 1'b1;
        step(2);

        // RLAST missing on beat 99
        lst_burst = s_rburst; lst_mode = 2;
        pulse_start();
        wait_done("done_t5b");
        check("err_t5b", 128'(rd_err), 128'(1));
        lst_mode = 0; lst_burst = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
